// File: rtl/zedboard_led_pkg.sv
// zedboard_led_pkg: shared mode, direction and entry-value definitions for the LED sequencer
package zedboard_led_pkg;
  typedef enum logic [1:0] {COUNT = 2'd0, WALK = 2'd1, BOUNCE = 2'd2} mode_t;
  localparam logic LEFT = 1'b0;
  localparam logic RIGHT = 1'b1;
  localparam logic [7:0] COUNT_ENTRY = 8'h00;
  localparam logic [7:0] WALK_ENTRY = 8'h01;
  localparam logic [7:0] BOUNCE_ENTRY = 8'h01;
  function automatic mode_t next_mode(mode_t m);
    return m == COUNT ? WALK : m == WALK ? BOUNCE : COUNT;
  endfunction
  function automatic logic [7:0] entry_value(mode_t m);
    return m == COUNT ? COUNT_ENTRY : m == WALK ? WALK_ENTRY : BOUNCE_ENTRY;
  endfunction
endpackage

// File: rtl/zedboard_led_if.sv
// zedboard_led_if: LED drive bundle between the sequencer and the board pins
interface zedboard_led_if;
  logic [7:0] led;
  modport master (output led);
  modport slave (input led);
endinterface

// File: rtl/zedboard_led_top_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 625000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt = '0;
  assign tick = cnt == W'(DIV - 1);
  // count 0..DIV-1 and wrap; reset restarts the period
  always_ff @(posedge clk)
    cnt <= (rst || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/zedboard_led_top.sv
// zedboard_led_top: self-running counter/walk/bounce LED sequence for board bring-up
module zedboard_led_top
  import zedboard_led_pkg::*;
#(
  parameter int DIV = 625000,
  parameter int STEPS_PER_MODE = 16
) (
  input  logic clk,
  input  logic rst,
  zedboard_led_if.master bus
);
  localparam int SW = STEPS_PER_MODE > 1 ? $clog2(STEPS_PER_MODE) : 1;
  logic tick;
  logic last;
  mode_t mode = COUNT;
  logic dir = LEFT;
  logic [SW-1:0] step_idx = '0;
  logic [7:0] led_q = COUNT_ENTRY;
  logic [7:0] step_val;
  logic step_dir;
  tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign last = step_idx == SW'(STEPS_PER_MODE - 1);
  assign bus.led = led_q;
  // next pattern value within the current mode; bounce turns around at the ends
  always_comb begin
    step_val = mode == COUNT ? led_q + 8'd1 :
               mode == WALK ? {led_q[6:0], led_q[7]} :
               dir == LEFT ? led_q << 1 : led_q >> 1;
    step_dir = mode != BOUNCE ? dir :
               step_val == 8'h80 ? RIGHT :
               step_val == 8'h01 ? LEFT : dir;
  end
  // advance the pattern on each tick, switching mode after STEPS_PER_MODE ticks
  always_ff @(posedge clk)
    if (rst) begin
      mode <= COUNT;
      dir <= LEFT;
      step_idx <= '0;
      led_q <= COUNT_ENTRY;
    end else if (tick) begin
      if (last) begin
        step_idx <= '0;
        mode <= next_mode(mode);
        led_q <= entry_value(next_mode(mode));
        dir <= LEFT;
      end else begin
        step_idx <= step_idx + 1'b1;
        led_q <= step_val;
        dir <= step_dir;
      end
    end
endmodule

// File: tb/tb_zedboard_led_top.sv
// tb_zedboard_led_top: directed checks of the LED sequencer
module tb_zedboard_led_top;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int changes2 = 0;
  logic [7:0] prev2 = 8'h00;
  zedboard_led_if bus0();
  zedboard_led_if bus1();
  zedboard_led_if bus2();
  zedboard_led_top #(.DIV(4), .STEPS_PER_MODE(16)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
  zedboard_led_top #(.DIV(4), .STEPS_PER_MODE(512)) u1 (.clk(clk), .rst(rst1), .bus(bus1));
  zedboard_led_top #(.DIV(500), .STEPS_PER_MODE(16)) u2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #4 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus2.led !== prev2) changes2++;
    prev2 = bus2.led;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_no_reset;
    while (cyc < 5250) step(1);
    checks++;
    if (changes2 !== 10) begin
      errors++;
      $display("FAIL no_reset_changes got=%0d exp=10", changes2);
    end
    checks++;
    if (bus2.led !== 8'h0A) begin
      errors++;
      $display("FAIL no_reset_final got=%h exp=0a", bus2.led);
    end
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    step(2);
    checks++;
    if (bus0.led !== 8'h00) begin
      errors++;
      $display("FAIL reset_led got=%h exp=00", bus0.led);
    end
    rst0 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step(1);
      checks++;
      if (bus0.led !== (e == 4 ? 8'h01 : 8'h00)) begin
        errors++;
        $display("FAIL release_edge%0d got=%h exp=%h", e, bus0.led, e == 4 ? 8'h01 : 8'h00);
      end
    end
    step(3);
    checks++;
    if (bus0.led !== 8'h01) begin
      errors++;
      $display("FAIL tick_hold got=%h exp=01", bus0.led);
    end
  endtask

  task automatic test_count;
    for (int t = 2; t <= 15; t++) begin
      step(t == 2 ? 1 : 4);
      checks++;
      if (bus0.led !== 8'(t)) begin
        errors++;
        $display("FAIL count t=%0d got=%h exp=%h", t, bus0.led, 8'(t));
      end
    end
  endtask

  task automatic test_walk;
    logic [7:0] e;
    for (int t = 16; t <= 31; t++) begin
      step(4);
      e = t == 16 || t == 24 ? 8'h01 : 8'h01 << (t < 24 ? t - 16 : t - 24);
      checks++;
      if (bus0.led !== e) begin
        errors++;
        $display("FAIL walk t=%0d got=%h exp=%h", t, bus0.led, e);
      end
    end
  endtask

  task automatic test_bounce;
    logic [7:0] e;
    for (int t = 32; t <= 48; t++) begin
      step(4);
      e = t == 32 ? 8'h01 : t <= 39 ? 8'h01 << (t - 32) : t <= 46 ? 8'h80 >> (t - 39) :
          t == 47 ? 8'h02 : 8'h00;
      checks++;
      if (bus0.led !== e) begin
        errors++;
        $display("FAIL bounce t=%0d got=%h exp=%h", t, bus0.led, e);
      end
    end
  endtask

  task automatic test_mid_reset;
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    step(4 * 41);
    checks++;
    if (bus0.led !== 8'h20) begin
      errors++;
      $display("FAIL mid_setup got=%h exp=20", bus0.led);
    end
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    checks++;
    if (bus0.led !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=00", bus0.led);
    end
    step(3);
    checks++;
    if (bus0.led !== 8'h00) begin
      errors++;
      $display("FAIL mid_hold got=%h exp=00", bus0.led);
    end
    for (int t = 1; t <= 3; t++) begin
      step(t == 1 ? 1 : 4);
      checks++;
      if (bus0.led !== 8'(t)) begin
        errors++;
        $display("FAIL mid_count t=%0d got=%h exp=%h", t, bus0.led, 8'(t));
      end
    end
  endtask

  task automatic test_count_wrap;
    rst1 = 1'b1;
    step(1);
    rst1 = 1'b0;
    step(4 * 255);
    checks++;
    if (bus1.led !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_ff got=%h exp=ff", bus1.led);
    end
    step(4);
    checks++;
    if (bus1.led !== 8'h00) begin
      errors++;
      $display("FAIL wrap_00 got=%h exp=00", bus1.led);
    end
    step(4);
    checks++;
    if (bus1.led !== 8'h01) begin
      errors++;
      $display("FAIL wrap_01 got=%h exp=01", bus1.led);
    end
  endtask

  initial begin
    test_no_reset;
    test_reset;
    test_count;
    test_walk;
    test_bounce;
    test_mid_reset;
    test_count_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
